// File: rtl/key_conditioner_pkg.sv
// Shared constants and types for the key conditioner: default timing,
// channel numbering and the auto-repeat state encoding.
package key_pkg;

    // Default timing for a 50 MHz clock.
    localparam int unsigned DEB_CYCLES_DEF = 32'd1000000;   // 20 ms
    localparam int unsigned RPT_DELAY_DEF  = 32'd25000000;  // 500 ms
    localparam int unsigned RPT_PERIOD_DEF = 32'd5000000;   // 100 ms

    // Debounce channel numbering. Left and right must stay 0 and 1: the
    // repeat engines are indexed by these values.
    localparam int NUM_CH   = 32'sd5;
    localparam int NUM_DIR  = 32'sd2;
    localparam int CH_LEFT  = 32'sd0;
    localparam int CH_RIGHT = 32'sd1;
    localparam int CH_PAUSE = 32'sd2;
    localparam int CH_SW0   = 32'sd3;
    localparam int CH_SW1   = 32'sd4;

    // Auto-repeat engine states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_e;

    // Width of a counter that must be able to hold the value 'terminal'.
    function automatic int unsigned cnt_width(input int unsigned terminal);
        int unsigned w;
        w = $clog2(terminal + 32'd1);
        if (w < 32'd1) begin
            w = 32'd1;
        end else begin
            w = w;
        end
        return w;
    endfunction

    // Larger of two unsigned values.
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        int unsigned m;
        if (a > b) begin
            m = a;
        end else begin
            m = b;
        end
        return m;
    endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// Button/switch bundle between the raw panel inputs, the key conditioner
// and the game logic it feeds.
interface key_conditioner_if;

    logic       left_raw;
    logic       right_raw;
    logic       pause_raw;
    logic [1:0] sw_raw;

    logic       left_shift;
    logic       right_shift;
    logic       pause;
    logic [1:0] sw;
    logic       key_busy;

    // Panel / stimulus side: drives raw inputs, observes conditioned outputs.
    modport master (
        output left_raw, right_raw, pause_raw, sw_raw,
        input  left_shift, right_shift, pause, sw, key_busy
    );

    // Conditioner side.
    modport slave (
        input  left_raw, right_raw, pause_raw, sw_raw,
        output left_shift, right_shift, pause, sw, key_busy
    );

endinterface

// File: rtl/key_conditioner_debounce_cell.sv
// One debounced input: 2-flop synchronizer, stability counter, accepted
// (stable) level and a one-cycle pulse on an accepted 0->1 change.
module debounce_cell
    import key_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk_50m,
    input  logic rst,
    input  logic i_raw,
    output logic o_stable,
    output logic o_press
);

    localparam int unsigned      CNT_W    = cnt_width(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEB_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    logic             w_update;
    logic [CNT_W-1:0] w_cnt_next;

    // Bring the asynchronous input into the clock domain.
    always_ff @(posedge clk_50m) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Count consecutive cycles that disagree with the accepted level; the
    // terminal count accepts the new level and reloads the counter.
    always_comb begin
        w_update   = 1'b0;
        w_cnt_next = CNT_ZERO;
        if (r_sync2 == r_stable) begin
            w_cnt_next = CNT_ZERO;
        end else if (r_cnt >= CNT_TERM) begin
            w_update   = 1'b1;
            w_cnt_next = CNT_ZERO;
        end else begin
            w_cnt_next = r_cnt + CNT_ONE;
        end
    end

    // Hold the counter, the accepted level and the press pulse.
    always_ff @(posedge clk_50m) begin
        if (!rst) begin
            r_cnt    <= CNT_ZERO;
            r_stable <= 1'b0;
            r_press  <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_next;
            r_stable <= w_update ? r_sync2 : r_stable;
            r_press  <= w_update & r_sync2;
        end
    end

    assign o_stable = r_stable;
    assign o_press  = r_press;

endmodule

// File: rtl/key_conditioner.sv
// Key conditioner: debounces three push-buttons and two slide-switch bits,
// turns left/right into press + auto-repeat move pulses, toggles pause on
// each press and reports whether any button is held.
module key_conditioner
    import key_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int unsigned RPT_DELAY  = RPT_DELAY_DEF,
    parameter int unsigned RPT_PERIOD = RPT_PERIOD_DEF
) (
    input  logic             clk_50m,
    input  logic             rst,
    key_conditioner_if.slave kbus
);

    localparam int unsigned       HOLD_W      = cnt_width(max_u(RPT_DELAY, RPT_PERIOD));
    localparam logic [HOLD_W-1:0] DELAY_TERM  = HOLD_W'(RPT_DELAY - 32'd1);
    localparam logic [HOLD_W-1:0] PERIOD_TERM = HOLD_W'(RPT_PERIOD - 32'd1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO   = {HOLD_W{1'b0}};
    localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(32'd1);

    logic [NUM_CH-1:0]  w_raw;
    logic [NUM_CH-1:0]  w_stable;
    logic [NUM_CH-1:0]  w_press;
    logic [NUM_DIR-1:0] w_shift;
    logic               w_both_held;
    // Switch bits are levels; their press pulses have no consumer.
    logic [1:0]         w_sw_press_unused;

    logic               r_pause;
    logic [1:0]         r_sw;
    logic               r_key_busy;

    assign w_raw[CH_LEFT]  = kbus.left_raw;
    assign w_raw[CH_RIGHT] = kbus.right_raw;
    assign w_raw[CH_PAUSE] = kbus.pause_raw;
    assign w_raw[CH_SW0]   = kbus.sw_raw[0];
    assign w_raw[CH_SW1]   = kbus.sw_raw[1];

    assign w_sw_press_unused = w_press[CH_SW1:CH_SW0];

    // Opposing directions held together cancel each other out.
    assign w_both_held = w_stable[CH_LEFT] & w_stable[CH_RIGHT];

    for (genvar g_ch = 0; g_ch < NUM_CH; g_ch++) begin : g_deb
        debounce_cell #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk_50m  (clk_50m),
            .rst      (rst),
            .i_raw    (w_raw[g_ch]),
            .o_stable (w_stable[g_ch]),
            .o_press  (w_press[g_ch])
        );
    end

    for (genvar g_dir = 0; g_dir < NUM_DIR; g_dir++) begin : g_rpt
        rpt_state_e        r_state;
        rpt_state_e        w_state_next;
        logic [HOLD_W-1:0] r_hold;
        logic [HOLD_W-1:0] w_hold_next;
        logic              r_shift;
        logic              w_shift_next;

        // Repeat engine state, hold counter and registered move pulse.
        always_ff @(posedge clk_50m) begin
            if (!rst) begin
                r_state <= ST_IDLE;
                r_hold  <= HOLD_ZERO;
                r_shift <= 1'b0;
            end else begin
                r_state <= w_state_next;
                r_hold  <= w_hold_next;
                r_shift <= w_shift_next;
            end
        end

        // Press fires at once, then one pulse after the hold delay, then one
        // per period; release or a conflicting opposite key drops to idle.
        always_comb begin
            w_state_next = r_state;
            w_hold_next  = r_hold;
            w_shift_next = 1'b0;
            if (!w_stable[g_dir]) begin
                w_state_next = ST_IDLE;
                w_hold_next  = HOLD_ZERO;
            end else if (w_both_held) begin
                w_state_next = ST_IDLE;
                w_hold_next  = HOLD_ZERO;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_press[g_dir]) begin
                            w_state_next = ST_HOLD;
                            w_hold_next  = HOLD_ZERO;
                            w_shift_next = 1'b1;
                        end else begin
                            w_state_next = ST_IDLE;
                            w_hold_next  = HOLD_ZERO;
                        end
                    end
                    ST_HOLD: begin
                        if (r_hold >= DELAY_TERM) begin
                            w_state_next = ST_REPEAT;
                            w_hold_next  = HOLD_ZERO;
                            w_shift_next = 1'b1;
                        end else begin
                            w_hold_next  = r_hold + HOLD_ONE;
                        end
                    end
                    ST_REPEAT: begin
                        if (r_hold >= PERIOD_TERM) begin
                            w_hold_next  = HOLD_ZERO;
                            w_shift_next = 1'b1;
                        end else begin
                            w_hold_next  = r_hold + HOLD_ONE;
                        end
                    end
                    default: begin
                        w_state_next = ST_IDLE;
                        w_hold_next  = HOLD_ZERO;
                    end
                endcase
            end
        end

        assign w_shift[g_dir] = r_shift;
    end

    // Registered pause level, switch selection and busy flag.
    always_ff @(posedge clk_50m) begin
        if (!rst) begin
            r_pause    <= 1'b0;
            r_sw       <= 2'b00;
            r_key_busy <= 1'b0;
        end else begin
            r_pause    <= r_pause ^ w_press[CH_PAUSE];
            r_sw       <= {w_stable[CH_SW1], w_stable[CH_SW0]};
            r_key_busy <= w_stable[CH_LEFT] | w_stable[CH_RIGHT] | w_stable[CH_PAUSE];
        end
    end

    assign kbus.left_shift  = w_shift[CH_LEFT];
    assign kbus.right_shift = w_shift[CH_RIGHT];
    assign kbus.pause       = r_pause;
    assign kbus.sw          = r_sw;
    assign kbus.key_busy    = r_key_busy;

endmodule
